// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage buffer: default widths, control-bit
// positions and the head-load source select.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 128;
  localparam int unsigned PIPE_CTRL_W = 16;

  localparam int unsigned CTRL_MEM_READ  = 0;
  localparam int unsigned CTRL_MEM_WRITE = 1;
  localparam int unsigned CTRL_JALR      = 2;
  localparam int unsigned CTRL_AUIPC     = 3;
  localparam int unsigned CTRL_BRANCH    = 4;
  localparam int unsigned CTRL_ALU_SRC   = 5;

  typedef enum logic {
    SRC_IN   = 1'b0,
    SRC_SKID = 1'b1
  } head_src_e;

  function automatic logic [1:0] occ_count(input logic head_v, input logic skid_v);
    return {1'b0, head_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One buffered pipeline entry: valid flag plus payload, payload written only on load.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_d,
  input  logic              load,
  input  logic [DATA_W-1:0] data_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              mem_op_d,
  output logic              valid_q,
  output logic [DATA_W-1:0] data_q,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic              mem_op_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      ctrl_q   <= '0;
      mem_op_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        data_q   <= data_d;
        ctrl_q   <= ctrl_d;
        mem_op_q <= mem_op_d;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer with valid/allow handshake and memory-request gating.
// Define PIPE_SKID_EN for a head-plus-skid build with registered allow_in.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              ready_go_in,
  output logic              allow_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              mem_op_in,
  input  logic              flush,
  input  logic              kill,
  input  logic              hold,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ready_go_out,
  input  logic              allow_in_next,
  output logic              ram_req,
  input  logic              mem_addr_ok,
  output logic [1:0]        occupancy
);

  logic              head_v, head_mem_q, head_mem;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_ctrl;
  logic              head_v_d, head_load, head_mem_d;
  logic [DATA_W-1:0] head_data_d;
  logic [CTRL_W-1:0] head_ctrl_d;
  logic              accept, depart;

  // Stale mem_op of an empty head must not stall ready_go_out.
  assign head_mem     = head_v & head_mem_q;
  assign valid_out    = head_v;
  assign data_out     = head_data;
  assign ctrl_out     = head_ctrl & {CTRL_W{head_v}};
  assign ram_req      = head_v & head_mem & allow_in_next & ~hold;
  assign ready_go_out = (~head_mem | (ram_req & mem_addr_ok)) & ~hold;
  assign depart       = head_v & ready_go_out & allow_in_next;
  assign accept       = valid_in & ready_go_in & ~flush & allow_in;

`ifdef PIPE_SKID_EN
  logic              skid_v, skid_mem;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_v_d, skid_load;
  head_src_e         head_src;

  assign allow_in  = ~skid_v;
  assign occupancy = occ_count(head_v, skid_v);

  // Skid is only ever valid behind a valid head, so it refills the head on depart.
  always_comb begin
    head_src    = skid_v ? SRC_SKID : SRC_IN;
    head_v_d    = ~kill & (skid_v | accept | (head_v & ~depart));
    head_load   = ~kill & ((accept & (~head_v | depart)) | (depart & skid_v));
    skid_v_d    = ~kill & ((skid_v & ~depart) | (accept & head_v & ~depart));
    skid_load   = ~kill & accept & head_v & ~depart;
    head_data_d = data_in;
    head_ctrl_d = ctrl_in;
    head_mem_d  = mem_op_in;
    if (head_src == SRC_SKID) begin
      head_data_d = skid_data;
      head_ctrl_d = skid_ctrl;
      head_mem_d  = skid_mem;
    end
  end

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_d  (skid_v_d),
    .load     (skid_load),
    .data_d   (data_in),
    .ctrl_d   (ctrl_in),
    .mem_op_d (mem_op_in),
    .valid_q  (skid_v),
    .data_q   (skid_data),
    .ctrl_q   (skid_ctrl),
    .mem_op_q (skid_mem)
  );
`else
  assign allow_in  = ~head_v | depart;
  assign occupancy = {1'b0, head_v};

  always_comb begin
    head_v_d    = ~kill & (accept | (head_v & ~depart));
    head_load   = ~kill & accept;
    head_data_d = data_in;
    head_ctrl_d = ctrl_in;
    head_mem_d  = mem_op_in;
  end
`endif

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_d  (head_v_d),
    .load     (head_load),
    .data_d   (head_data_d),
    .ctrl_d   (head_ctrl_d),
    .mem_op_d (head_mem_d),
    .valid_q  (head_v),
    .data_q   (head_data),
    .ctrl_q   (head_ctrl),
    .mem_op_q (head_mem_q)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus random traffic
// against a queue-based model. Honours PIPE_SKID_EN like the design.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in, ready_go_in, allow_in;
  logic [DW-1:0] data_in;
  logic [CW-1:0] ctrl_in;
  logic          mem_op_in, flush, kill, hold;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [CW-1:0] ctrl_out;
  logic          ready_go_out, allow_in_next, ram_req, mem_addr_ok;
  logic [1:0]    occupancy;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          m;
  } ent_t;

  ent_t q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .ready_go_in   (ready_go_in),
    .allow_in      (allow_in),
    .data_in       (data_in),
    .ctrl_in       (ctrl_in),
    .mem_op_in     (mem_op_in),
    .flush         (flush),
    .kill          (kill),
    .hold          (hold),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .ctrl_out      (ctrl_out),
    .ready_go_out  (ready_go_out),
    .allow_in_next (allow_in_next),
    .ram_req       (ram_req),
    .mem_addr_ok   (mem_addr_ok),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    valid_in = 0; ready_go_in = 1; data_in = '0; ctrl_in = '0; mem_op_in = 0;
    flush = 0; kill = 0; hold = 0; allow_in_next = 1; mem_addr_ok = 0;
  endtask

  // Check outputs against the model, clock once, update the model. Enter/leave at negedge.
  task automatic tick();
    ent_t        hd;
    int unsigned sz;
    logic        mv, mm, mr, mg, md, ma, macc;
    #1;
    sz = q.size();
    mv = (sz != 0);
    hd = '{d: '0, c: '0, m: 1'b0};
    if (mv) hd = q[0];
    mm = mv & hd.m;
    mr = mv & mm & allow_in_next & ~hold;
    mg = (~mm | (mr & mem_addr_ok)) & ~hold;
    md = mv & mg & allow_in_next;
`ifdef PIPE_SKID_EN
    ma = (sz < 2);
`else
    ma = (sz == 0) || md;
`endif
    macc = valid_in & ready_go_in & ~flush & ma;
    chk("valid_out", valid_out, mv);
    if (mv) chk("data_out", data_out, hd.d);
    chk("ctrl_out", ctrl_out, mv ? hd.c : CW'(0));
    chk("ram_req", ram_req, mr);
    chk("ready_go_out", ready_go_out, mg);
    chk("allow_in", allow_in, ma);
    chk("occupancy", occupancy, sz[1:0]);
    @(posedge clk);
    if (kill) q.delete();
    else begin
      if (md) void'(q.pop_front());
      if (macc) q.push_back('{d: data_in, c: ctrl_in, m: mem_op_in});
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 0;
    #2;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_ram_req", ram_req, 1'b0);
    chk("rst_ctrl_out", ctrl_out, '0);
    chk("rst_data_out", data_out, '0);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_allow_in", allow_in, 1'b1);
    @(negedge clk);
    rst_n = 1;

    // Single non-memory entry, accepted on the first edge after reset.
    valid_in = 1; data_in = 32'hA5; ctrl_in = 8'h3C; mem_op_in = 0; allow_in_next = 0;
    tick();
    valid_in = 0;
    #1;
    chk("a5_valid", valid_out, 1'b1);
    chk("a5_data", data_out, 32'hA5);
    chk("a5_rgo", ready_go_out, 1'b1);
    allow_in_next = 1;
    tick();
    chk("a5_gone", valid_out, 1'b0);

    // Memory head waits three cycles for mem_addr_ok.
    valid_in = 1; data_in = 32'h33; ctrl_in = 8'h03; mem_op_in = 1; mem_addr_ok = 0;
    tick();
    valid_in = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mem_ram_req_wait", ram_req, 1'b1);
      chk("mem_rgo_wait", ready_go_out, 1'b0);
      tick();
    end
    mem_addr_ok = 1;
    #1;
    chk("mem_ram_req_ok", ram_req, 1'b1);
    tick();
    chk("mem_departed", valid_out, 1'b0);
    mem_addr_ok = 0;

    // Two entries against a blocked downstream, then release.
    allow_in_next = 0; mem_op_in = 0; valid_in = 1; data_in = 32'h1; ctrl_in = 8'h11;
    tick();
    data_in = 32'h2; ctrl_in = 8'h22;
    tick();
    valid_in = 0;
    tick();
`ifdef PIPE_SKID_EN
    chk("skid_occ2", occupancy, 2'd2);
    chk("skid_allow0", allow_in, 1'b0);
`endif
    allow_in_next = 1;
    #1;
    chk("rel_first", data_out, 32'h1);
    tick();
`ifdef PIPE_SKID_EN
    chk("rel_second", data_out, 32'h2);
`endif
    tick();
    tick();

    // Kill with a full stage and an incoming entry in the same cycle.
    allow_in_next = 0; valid_in = 1; data_in = 32'h44; ctrl_in = 8'hF0;
    tick();
    data_in = 32'h55;
    tick();
    data_in = 32'h66; kill = 1;
    tick();
    kill = 0; valid_in = 0;
    chk("kill_occ", occupancy, 2'd0);
    chk("kill_valid", valid_out, 1'b0);
    chk("kill_ctrl", ctrl_out, '0);

    // Flush drops the incoming entry, held entry survives.
    valid_in = 1; data_in = 32'h7; ctrl_in = 8'h77;
    tick();
    data_in = 32'h99; flush = 1;
    tick();
    flush = 0; valid_in = 0;
    chk("flush_keep", data_out, 32'h7);
    chk("flush_occ", occupancy, 2'd1);
    tick();

    // Hold stalls a ready head.
    hold = 1; allow_in_next = 1;
    #1;
    chk("hold_rgo", ready_go_out, 1'b0);
    tick();
    tick();
    hold = 0;
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      valid_in      = ($urandom_range(0, 3) != 0);
      ready_go_in   = ($urandom_range(0, 4) != 0);
      data_in       = $urandom;
      ctrl_in       = CW'($urandom_range(0, 255));
      mem_op_in     = $urandom_range(0, 1);
      flush         = ($urandom_range(0, 7) == 0);
      kill          = ($urandom_range(0, 19) == 0);
      hold          = ($urandom_range(0, 5) == 0);
      allow_in_next = ($urandom_range(0, 2) != 0);
      mem_addr_ok   = $urandom_range(0, 1);
      tick();
    end

    // Asynchronous reset with entries held.
    idle();
    allow_in_next = 0; valid_in = 1; data_in = 32'hC1;
    tick();
    data_in = 32'hC2;
    tick();
    valid_in = 0;
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid", valid_out, 1'b0);
    chk("arst_data", data_out, '0);
    chk("arst_ctrl", ctrl_out, '0);
    chk("arst_occ", occupancy, 2'd0);
    chk("arst_ram_req", ram_req, 1'b0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 128, unregistered-use payload width (pc, rs data, imm, instruction).
REQ-002 SHALL have parameter CTRL_W, default 16, control-bit width; these bits are masked by valid at output.
REQ-003 SHALL have ports clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-004 SHALL have ports valid_in in 1, upstream valid; ready_go_in in 1, upstream done; allow_in out 1, stage can accept.
REQ-005 SHALL have ports data_in in DATA_W; ctrl_in in CTRL_W; mem_op_in in 1, entry needs memory request.
REQ-006 SHALL have ports flush in 1, drop incoming; kill in 1, drop all held entries; hold in 1, stall stage.
REQ-007 SHALL have ports valid_out out 1; data_out out DATA_W; ctrl_out out CTRL_W; ready_go_out out 1.
REQ-008 SHALL have ports allow_in_next in 1, downstream can accept; ram_req out 1; mem_addr_ok in 1, memory accepted address.
REQ-009 SHALL have port occupancy out 2, number of held entries (0..2).

Function
REQ-010 SHALL define accept = valid_in & ready_go_in & ~flush & allow_in, sampled at clk edge.
REQ-011 SHALL drive ram_req = valid_out & mem_op(head) & allow_in_next & ~hold, combinationally.
REQ-012 SHALL drive ready_go_out = (~mem_op(head) | (ram_req & mem_addr_ok)) & ~hold.
REQ-013 SHALL define depart = valid_out & ready_go_out & allow_in_next; head entry leaves on that edge.
REQ-014 SHALL drive ctrl_out = head ctrl & {CTRL_W{valid_out}}; data_out unmasked head data.
REQ-015 SHALL keep data_out/ctrl_out/mem_op stable while valid_out=1 and depart=0.
REQ-016 SHALL capture incoming payload only on accept; no payload register toggles otherwise.
REQ-017 SHALL have latency one cycle: accept at edge N -> valid_out=1 after edge N when stage was empty.
REQ-018 SHALL on kill clear all held valids at next edge, overriding depart and accept in same cycle.
REQ-019 SHALL on flush with kill=0 not affect held entries; incoming entry discarded.
REQ-020 SHALL preserve strict FIFO order; no entry duplicated or lost except by flush/kill.
REQ-021 SHALL with hold=1 keep ram_req=0 and ready_go_out=0; held entries retained.
REQ-022 SHALL on simultaneous accept and depart with one entry held replace head with incoming, occupancy stays 1.

Reset
REQ-023 SHALL on rst_n=0 asynchronously clear all valids, payload, ctrl, mem_op registers to 0.
REQ-024 SHALL during reset drive valid_out=0, ram_req=0, ctrl_out=0, data_out=0, occupancy=0, allow_in=1 (skid build) or 1 (non-skid).
REQ-025 SHALL accept first entry at the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL with PIPE_SKID_EN defined instantiate head plus one skid entry; allow_in = ~skid_valid, a register output with no combinational path from allow_in_next/hold/mem_addr_ok.
REQ-027 SHALL with PIPE_SKID_EN: accept while head held and no depart -> entry to skid, occupancy 2; depart with skid valid -> skid moves to head same edge.
REQ-028 SHALL without PIPE_SKID_EN hold single entry; allow_in = ~valid_out | depart (combinational); occupancy never exceeds 1.

Structure
REQ-029 SHALL take DATA_W/CTRL_W defaults and ctrl bit index constants (mem_read, mem_write, jalr, auipc, branch, alu_src) from shared package pipe_pkg.
REQ-030 SHALL factor one payload-plus-valid register into sub-module pipe_entry, instantiated once or twice.

Verification
REQ-031 SHALL test empty stage, valid_in=1, ready_go_in=1, data_in=0xA5, mem_op_in=0 -> valid_out=1, data_out=0xA5 next cycle, ready_go_out=1.
REQ-032 SHALL test mem_op head, allow_in_next=1, mem_addr_ok=0 for 3 cycles then 1 -> ram_req=1 all 4 cycles, depart on 4th edge only.
REQ-033 SHALL test skid build, allow_in_next=0, entries 0x1,0x2 accepted -> occupancy=2, allow_in=0; release -> outputs 0x1 then 0x2 on consecutive cycles.
REQ-034 SHALL test kill=1 with occupancy=2 and valid_in=1 same cycle -> occupancy=0, valid_out=0, ctrl_out=0 next cycle.
REQ-035 SHALL test flush=1 with valid_in=1, held entry 0x7 -> 0x7 retained, incoming not captured, occupancy unchanged.
REQ-036 SHALL test rst_n asserted mid-transfer, occupancy=2 -> all outputs zero immediately without clock edge.
